// File: rtl/audio_dac_serializer.sv
// Stereo DAC serializer: valid/ready pair FIFO feeding an MSB-first BCLK shifter with DSP-pulse or I2S framing.
// Outputs move one clk25 cycle after a detected BCLK fall; sample_ready drops only while the FIFO is full.

module audio_dac_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_vld,
  output logic                      o_wr_rdy,
  input  logic [W-1:0]              i_wr_dat,
  output logic                      o_rd_vld,
  input  logic                      i_rd_en,
  output logic [W-1:0]              o_rd_dat,
  output logic [$clog2(DEPTH):0]    o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic           w_push;
  logic           w_pop;
  logic           w_full;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_wr_rdy = !w_full;
  assign o_rd_vld = (r_wr_ptr != r_rd_ptr);
  assign o_level  = r_wr_ptr - r_rd_ptr;
  assign o_rd_dat = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_push   = i_wr_vld && o_wr_rdy;
  assign w_pop    = i_rd_en && o_rd_vld;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module audio_dac_serializer #(
  parameter int SAMPLE_W      = 16,
  parameter int SLOT_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int BCLK_SYNC     = 0,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                            clk25,
  input  logic                            reset25,
  input  logic                            codec_bclk_i,
  output logic                            codec_dacdat,
  output logic                            codec_daclrc,
  output logic                            codec_adclrc,
  input  logic                            enable,
  input  logic                            fmt_i2s,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  input  logic [SAMPLE_W-1:0]             sample_left,
  input  logic [SAMPLE_W-1:0]             sample_right,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     underrun_count
);
  localparam int                CNT_W    = $clog2(2*SLOT_W);
  localparam int                IDX_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2*SLOT_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cntr;
  logic [CNT_W-1:0]    w_cntr_nxt;
  pair_t               r_hold;
  pair_t               r_last;
  pair_t               w_hold_nxt;
  pair_t               w_fifo_dat;
  pair_t               w_wr_dat;
  logic                r_fmt;
  logic                w_fmt_nxt;
  logic                w_load;
  logic                w_pop;
  logic                w_fifo_vld;
  logic                w_bclk_s;
  logic                r_hist;
  logic                w_fall;
  logic                w_right_slot;
  logic                w_dat_nxt;
  logic                w_lrc_nxt;
  int                  w_slot_bit;
  int                  w_data_bit;
  logic [IDX_W-1:0]    w_idx;
  logic [SAMPLE_W-1:0] w_word;
  logic [15:0]         r_underrun;

  generate
    if (BCLK_SYNC > 0) begin : g_sync
      logic [BCLK_SYNC-1:0] r_sync;
      always_ff @(posedge clk25 or posedge reset25) begin
        if (reset25) r_sync <= '0;
        else         r_sync <= BCLK_SYNC'({r_sync, codec_bclk_i});
      end
      assign w_bclk_s = r_sync[BCLK_SYNC-1];
    end else begin : g_nosync
      assign w_bclk_s = codec_bclk_i;
    end
  endgenerate

  // History resets low so a BCLK held low through reset release is not a fall.
  always_ff @(posedge clk25 or posedge reset25) begin
    if (reset25) r_hist <= 1'b0;
    else         r_hist <= w_bclk_s;
  end

  assign w_fall = !w_bclk_s && r_hist;

  assign w_wr_dat.left  = sample_left;
  assign w_wr_dat.right = sample_right;

  audio_dac_fifo #(
    .W     (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk25),
    .rst      (reset25),
    .i_wr_vld (sample_valid),
    .o_wr_rdy (sample_ready),
    .i_wr_dat (w_wr_dat),
    .o_rd_vld (w_fifo_vld),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_level  (fifo_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cntr_nxt  = r_bit_cntr;
    w_load      = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            w_state_nxt = S_RUN;
            w_cntr_nxt  = '0;
            w_load      = 1'b1;
          end
        end
        S_RUN: begin
          if (r_bit_cntr == CNT_LAST) begin
            w_cntr_nxt = '0;
            if (enable) w_load = 1'b1;
            else        w_state_nxt = S_IDLE;
          end else begin
            w_cntr_nxt = r_bit_cntr + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_pop = w_load && w_fifo_vld;

  // Frame load: fresh pair if available, otherwise silence or a repeat of the last pair.
  always_comb begin
    w_hold_nxt = r_hold;
    w_fmt_nxt  = r_fmt;
    if (w_load) begin
      w_fmt_nxt = fmt_i2s;
      if (w_fifo_vld)              w_hold_nxt = w_fifo_dat;
      else if (UNDERRUN_ZERO != 0) w_hold_nxt = '0;
      else                         w_hold_nxt = r_last;
    end
  end

  always_comb begin
    w_right_slot = (int'(w_cntr_nxt) >= SLOT_W);
    w_slot_bit   = w_right_slot ? int'(w_cntr_nxt) - SLOT_W : int'(w_cntr_nxt);
    w_data_bit   = w_fmt_nxt ? w_slot_bit - 1 : w_slot_bit;
    w_word       = w_right_slot ? w_hold_nxt.right : w_hold_nxt.left;
    w_idx        = '0;
    w_dat_nxt    = 1'b0;
    w_lrc_nxt    = 1'b0;
    if (w_state_nxt == S_RUN) begin
      if (w_data_bit >= 0 && w_data_bit < SAMPLE_W) begin
        w_idx     = IDX_W'(SAMPLE_W - 1 - w_data_bit);
        w_dat_nxt = w_word[w_idx];
      end
      w_lrc_nxt = w_fmt_nxt ? w_right_slot : (w_cntr_nxt == '0);
    end
  end

  always_ff @(posedge clk25 or posedge reset25) begin
    if (reset25) begin
      r_state      <= S_IDLE;
      r_bit_cntr   <= '0;
      r_hold       <= '0;
      r_last       <= '0;
      r_fmt        <= 1'b0;
      r_underrun   <= '0;
      codec_dacdat <= 1'b0;
      codec_daclrc <= 1'b0;
    end else if (w_fall) begin
      r_state      <= w_state_nxt;
      r_bit_cntr   <= w_cntr_nxt;
      r_hold       <= w_hold_nxt;
      r_fmt        <= w_fmt_nxt;
      codec_dacdat <= w_dat_nxt;
      codec_daclrc <= w_lrc_nxt;
      if (w_pop) r_last <= w_fifo_dat;
      if (w_load && !w_fifo_vld && r_underrun != 16'hFFFF) begin
        r_underrun <= r_underrun + 16'd1;
      end
    end
  end

  assign codec_adclrc   = 1'b0;
  assign underrun_count = r_underrun;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: two instances (repeat-last and zero underrun policies) against a frame-level model.
module tb_audio_dac_serializer;
  localparam int SLOT  = 32;
  localparam int DEPTH = 4;
  localparam int FRAME = 64;

  logic        clk25 = 1'b0;
  logic        reset25 = 1'b1;
  logic        bclk = 1'b1;
  logic        enable = 1'b0;
  logic        fmt_i2s = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;

  logic        o_dat  [2];
  logic        o_lrc  [2];
  logic        o_adc  [2];
  logic        o_rdy  [2];
  logic [2:0]  o_lvl  [2];
  logic [15:0] o_urun [2];

  int checks = 0;
  int failures = 0;

  logic [31:0] q[$];
  bit          m_run;
  int          m_cnt;
  bit          m_fmt;
  logic [31:0] m_last;
  logic [63:0] m_frame [2];
  int          m_urun;

  always #20 clk25 = ~clk25;

  audio_dac_serializer #(
    .SAMPLE_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .BCLK_SYNC(0), .UNDERRUN_ZERO(0)
  ) dut0 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(bclk),
    .codec_dacdat(o_dat[0]), .codec_daclrc(o_lrc[0]), .codec_adclrc(o_adc[0]),
    .enable(enable), .fmt_i2s(fmt_i2s), .sample_valid(sample_valid), .sample_ready(o_rdy[0]),
    .sample_left(sample_left), .sample_right(sample_right),
    .fifo_level(o_lvl[0]), .underrun_count(o_urun[0])
  );

  audio_dac_serializer #(
    .SAMPLE_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .BCLK_SYNC(0), .UNDERRUN_ZERO(1)
  ) dut1 (
    .clk25(clk25), .reset25(reset25), .codec_bclk_i(bclk),
    .codec_dacdat(o_dat[1]), .codec_daclrc(o_lrc[1]), .codec_adclrc(o_adc[1]),
    .enable(enable), .fmt_i2s(fmt_i2s), .sample_valid(sample_valid), .sample_ready(o_rdy[1]),
    .sample_left(sample_left), .sample_right(sample_right),
    .fifo_level(o_lvl[1]), .underrun_count(o_urun[1])
  );

  // Whole 64-bit frame as it should appear on the wire, bit 63 first.
  function automatic logic [63:0] frame_of(input logic [31:0] p, input bit i2s);
    if (i2s) return {1'b0, p[31:16], 15'b0, 1'b0, p[15:0], 15'b0};
    return {p[31:16], 16'b0, p[15:0], 16'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 1'b0;
    m_cnt = 0;
    m_fmt = 1'b0;
    m_last = '0;
    m_frame[0] = '0;
    m_frame[1] = '0;
    m_urun = 0;
  endtask

  task automatic model_fall();
    bit load;
    logic [31:0] p;
    load = 1'b0;
    if (!m_run) begin
      if (enable) begin m_run = 1'b1; m_cnt = 0; load = 1'b1; end
    end else if (m_cnt == FRAME-1) begin
      m_cnt = 0;
      if (enable) load = 1'b1;
      else        m_run = 1'b0;
    end else begin
      m_cnt++;
    end
    if (load) begin
      m_fmt = fmt_i2s;
      if (q.size() > 0) begin
        p = q.pop_front();
        m_last = p;
        m_frame[0] = frame_of(p, m_fmt);
        m_frame[1] = m_frame[0];
      end else begin
        m_frame[0] = frame_of(m_last, m_fmt);
        m_frame[1] = frame_of(32'd0, m_fmt);
        if (m_urun < 65535) m_urun++;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] sh;
    logic e_dat;
    logic e_lrc;
    for (int k = 0; k < 2; k++) begin
      sh    = m_frame[k] << m_cnt;
      e_dat = m_run ? sh[63] : 1'b0;
      e_lrc = m_run && (m_fmt ? (m_cnt >= SLOT) : (m_cnt == 0));
      check($sformatf("dacdat u%0d bit%0d", k, m_cnt), 32'(o_dat[k]), 32'(e_dat));
      check($sformatf("daclrc u%0d bit%0d", k, m_cnt), 32'(o_lrc[k]), 32'(e_lrc));
      check($sformatf("adclrc u%0d", k), 32'(o_adc[k]), 32'd0);
      check($sformatf("fifo_level u%0d", k), 32'(o_lvl[k]), 32'(q.size()));
      check($sformatf("ready u%0d", k), 32'(o_rdy[k]), 32'(q.size() < DEPTH));
      check($sformatf("underrun u%0d", k), 32'(o_urun[k]), 32'(m_urun));
    end
  endtask

  task automatic write_pair(input logic [15:0] l, input logic [15:0] r);
    bit acc;
    @(negedge clk25);
    acc = (q.size() < DEPTH);
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    @(negedge clk25);
    sample_valid = 1'b0;
    if (acc) q.push_back({l, r});
    check_all();
  endtask

  // One BCLK period; an optional write lands in the same clk25 cycle as the falling-edge update.
  task automatic step(input bit wr, input logic [15:0] l, input logic [15:0] r);
    bit acc;
    @(negedge clk25);
    bclk = 1'b0;
    acc = wr && (q.size() < DEPTH);
    if (wr) begin
      sample_valid = 1'b1;
      sample_left  = l;
      sample_right = r;
    end
    @(negedge clk25);
    bclk = 1'b1;
    sample_valid = 1'b0;
    model_fall();
    if (acc) q.push_back({l, r});
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk25);
    check_all();
    reset25 = 1'b0;
    @(negedge clk25);
    check_all();

    // DSP frame, then a mid-frame format change that must wait for the next load.
    enable = 1'b1;
    fmt_i2s = 1'b0;
    write_pair(16'hA5C3, 16'h0F01);
    step(0, '0, '0);
    check("dsp_lrc_bit0", 32'(o_lrc[0]), 32'd1);
    check("dsp_msb_bit0", 32'(o_dat[0]), 32'd1);
    repeat (29) step(0, '0, '0);
    fmt_i2s = 1'b1;
    repeat (34) step(0, '0, '0);

    // I2S frame with the same data.
    write_pair(16'hA5C3, 16'h0F01);
    step(0, '0, '0);
    step(0, '0, '0);
    check("i2s_left_msb_bit1", 32'(o_dat[0]), 32'd1);
    check("i2s_lrc_left", 32'(o_lrc[0]), 32'd0);
    repeat (31) step(0, '0, '0);
    check("i2s_lrc_right", 32'(o_lrc[0]), 32'd1);
    repeat (5) step(0, '0, '0);
    check("i2s_right_bit37", 32'(o_dat[0]), 32'd1);
    repeat (26) step(0, '0, '0);
    enable = 1'b0;
    repeat (4) step(0, '0, '0);

    // Underrun: two pairs, four frames.
    write_pair(16'($urandom), 16'($urandom));
    write_pair(16'($urandom), 16'($urandom));
    enable = 1'b1;
    fmt_i2s = 1'($urandom);
    repeat (4*FRAME) step(0, '0, '0);
    check("underrun_after_4", 32'(o_urun[0]), 32'd2);
    enable = 1'b0;
    repeat (3) step(0, '0, '0);

    // Backpressure: six writes into a depth-4 FIFO, then pop/push collisions.
    repeat (6) write_pair(16'($urandom), 16'($urandom));
    check("level_full", 32'(o_lvl[0]), 32'd4);
    enable = 1'b1;
    step(1, 16'($urandom), 16'($urandom));
    repeat (63) step(0, '0, '0);
    step(1, 16'($urandom), 16'($urandom));
    check("level_pop_push", 32'(o_lvl[0]), 32'd3);

    // Enable drop at bit 10 finishes the frame, then re-enable.
    repeat (10) step(0, '0, '0);
    enable = 1'b0;
    repeat (53) step(0, '0, '0);
    repeat (3) step(0, '0, '0);
    enable = 1'b1;
    step(0, '0, '0);

    // Randomised run: writes, format flips and enable toggles at arbitrary bits.
    for (int i = 0; i < 20*FRAME; i++) begin
      if ($urandom_range(0, 31) == 0)  fmt_i2s = ~fmt_i2s;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      step(($urandom_range(0, 23) == 0), 16'($urandom), 16'($urandom));
    end

    // Async reset at bit 20 of a running frame.
    enable = 1'b0;
    repeat (FRAME+1) step(0, '0, '0);
    enable = 1'b1;
    write_pair(16'($urandom), 16'($urandom));
    write_pair(16'($urandom), 16'($urandom));
    repeat (21) step(0, '0, '0);
    @(negedge clk25);
    #2 reset25 = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk25);
    reset25 = 1'b0;
    step(0, '0, '0);
    check("underrun_after_reset", 32'(o_urun[0]), 32'd1);
    repeat (63) step(0, '0, '0);
    enable = 1'b0;
    repeat (2) step(0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
